// File: rtl/imem_responder.sv
// Instruction-memory responder: zero-latency read port for the fetch stage,
// plus a byte-serial programming port that packs little-endian bytes into
// words and writes them sequentially from word 0.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   mem_op                 fetch request type; only MEM_READ_EN is served
//   memory_inst_address    fetch byte address
//   memory_inst_data       instruction word (combinational), NOP_WORD if not servable
//   inst_fault             read request misaligned or out of range (combinational)
//   prog_start             pulse: start or restart a program load
//   prog_valid/prog_byte   programming byte stream, accepted when prog_ready
//   prog_last              marks the final byte of the image
//   prog_ready             byte stream may advance
//   loading                load in progress; holds the core in reset
//   words_loaded           words written since the last prog_start
//   prog_overflow          sticky: a byte arrived after the array was full

package imem_pkg;
    typedef logic [31:0] word;

    typedef enum logic [1:0] {
        MEM_IDLE     = 2'd0,
        MEM_READ_EN  = 2'd1,
        MEM_WRITE_EN = 2'd2
    } mem_en_t;
endpackage

module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter word         NOP_WORD    = 32'h0000_0013
) (
    input  logic                         clock,
    input  logic                         reset,
    input  mem_en_t                      mem_op,
    input  word                          memory_inst_address,
    output word                          memory_inst_data,
    output logic                         inst_fault,
    input  logic                         prog_start,
    input  logic                         prog_valid,
    input  logic [7:0]                   prog_byte,
    input  logic                         prog_last,
    output logic                         prog_ready,
    output logic                         loading,
    output logic [$clog2(DEPTH_WORDS):0] words_loaded,
    output logic                         prog_overflow
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   ptr_q, ptr_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    // Lanes 0..2 of the word being assembled; lane 3 is taken straight from
    // prog_byte on the completing beat. Unfilled lanes are always zero.
    logic [23:0]        asm_q, asm_d;
    logic               overflow_q, overflow_d;
    logic               loading_q, loading_d;
    logic               ready_q, ready_d;

    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    word                mem_wdata;
    word                mem_q [DEPTH_WORDS];

    logic               full;
    logic               rd_en;
    logic               misaligned;
    logic               out_of_range;

    assign full = (ptr_q == CNT_W'(DEPTH_WORDS));

    // State and control registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            overflow_q <= 1'b0;
            loading_q  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            overflow_q <= overflow_d;
            loading_q  <= loading_d;
            ready_q    <= ready_d;
        end
    end

    // Load FSM: next state, assembly, pointer and write port
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        mem_waddr  = ptr_q[IDX_W-1:0];
        mem_wdata  = '0;

        case (state_q)
            ST_IDLE: begin
                if (prog_start) begin
                    state_d    = ST_LOAD;
                    ptr_d      = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    overflow_d = 1'b0;
                end
            end

            ST_LOAD: begin
                if (prog_start) begin
                    // Restart wins over a byte presented in the same cycle
                    ptr_d      = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    overflow_d = 1'b0;
                end else if (prog_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (full) begin
                        overflow_d = 1'b1;
                    end
                    case (byte_cnt_q)
                        2'd0:    asm_d[7:0]   = prog_byte;
                        2'd1:    asm_d[15:8]  = prog_byte;
                        2'd2:    asm_d[23:16] = prog_byte;
                        default: begin
                            asm_d = '0;
                            if (!full) begin
                                mem_we    = 1'b1;
                                mem_wdata = {prog_byte, asm_q};
                                ptr_d     = ptr_q + CNT_W'(1);
                            end
                        end
                    endcase
                    if (prog_last) begin
                        state_d = (byte_cnt_q == 2'd3) ? ST_IDLE : ST_FLUSH;
                    end
                end
            end

            ST_FLUSH: begin
                state_d = ST_IDLE;
                asm_d   = '0;
                if (!full) begin
                    mem_we    = 1'b1;
                    mem_wdata = {8'h00, asm_q};
                    ptr_d     = ptr_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        loading_d = (state_d != ST_IDLE);
        ready_d   = (state_d == ST_LOAD);
    end

    // Instruction array; deliberately not reset so a program survives reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Zero-latency read path
    always_comb begin
        rd_en        = (mem_op == MEM_READ_EN);
        misaligned   = |memory_inst_address[1:0];
        out_of_range = |memory_inst_address[31:IDX_W+2];
        inst_fault   = rd_en && (misaligned || out_of_range);
        if (rd_en && !misaligned && !out_of_range && (state_q == ST_IDLE)) begin
            memory_inst_data = mem_q[memory_inst_address[IDX_W+1:2]];
        end else begin
            memory_inst_data = NOP_WORD;
        end
    end

    assign prog_ready    = ready_q;
    assign loading       = loading_q;
    assign words_loaded  = ptr_q;
    assign prog_overflow = overflow_q;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder (small array so overflow is reachable).
module tb_imem_responder;
    import imem_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WL_W  = $clog2(DEPTH) + 1;
    localparam word         NOP   = 32'h0000_0013;

    logic            clock = 1'b0;
    logic            reset;
    mem_en_t         mem_op;
    word             memory_inst_address;
    word             memory_inst_data;
    logic            inst_fault;
    logic            prog_start;
    logic            prog_valid;
    logic [7:0]      prog_byte;
    logic            prog_last;
    logic            prog_ready;
    logic            loading;
    logic [WL_W-1:0] words_loaded;
    logic            prog_overflow;

    int checks = 0;
    int errors = 0;

    // Reference: what each word should hold, and whether it was ever written
    word        model_mem [DEPTH];
    bit         model_vld [DEPTH];
    logic [7:0] img [$];

    imem_responder #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
        .clock               (clock),
        .reset               (reset),
        .mem_op              (mem_op),
        .memory_inst_address (memory_inst_address),
        .memory_inst_data    (memory_inst_data),
        .inst_fault          (inst_fault),
        .prog_start          (prog_start),
        .prog_valid          (prog_valid),
        .prog_byte           (prog_byte),
        .prog_last           (prog_last),
        .prog_ready          (prog_ready),
        .loading             (loading),
        .words_loaded        (words_loaded),
        .prog_overflow       (prog_overflow)
    );

    always #5 clock = ~clock;

    // Word w is bytes 4w..4w+3 of the image, little-endian, missing bytes zero;
    // words beyond the array are dropped.
    task automatic model_load(input int n);
        for (int w = 0; w < int'(DEPTH); w++) begin
            if (4 * w < n) begin
                word v = '0;
                for (int k = 0; k < 4; k++)
                    if (4 * w + k < n) v = v | (word'(img[4*w+k]) << (8 * k));
                model_mem[w] = v;
                model_vld[w] = 1'b1;
            end
        end
    endtask

    function automatic int exp_words(input int n);
        int w = (n + 3) / 4;
        return (w > int'(DEPTH)) ? int'(DEPTH) : w;
    endfunction

    function automatic logic exp_fault(input word a);
        return (a[1:0] != 2'b00) || (a >= 4 * DEPTH);
    endfunction

    // Drivers: all changes happen on the falling edge
    task automatic pulse_start();
        @(negedge clock);
        prog_start = 1'b1; prog_valid = 1'b0; prog_last = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic last);
        @(negedge clock);
        prog_start = 1'b0; prog_valid = 1'b1; prog_byte = b; prog_last = last;
    endtask

    task automatic drive_idle();
        @(negedge clock);
        prog_start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0;
    endtask

    task automatic rd(input mem_en_t op, input word a, output word d, output logic f);
        mem_op = op; memory_inst_address = a;
        #1;
        d = memory_inst_data; f = inst_fault;
    endtask

    task automatic test_reset();
        word d; logic f;
        reset = 1'b1; mem_op = MEM_IDLE; memory_inst_address = '0;
        prog_start = 1'b0; prog_valid = 1'b0; prog_byte = '0; prog_last = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (loading !== 1'b0 || prog_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl loading=%b ready=%b exp 0 0", loading, prog_ready);
        end
        checks++;
        if (words_loaded !== '0 || prog_overflow !== 1'b0) begin
            errors++; $display("FAIL reset_cnt words=%0d ovf=%b exp 0 0", words_loaded, prog_overflow);
        end
        rd(MEM_READ_EN, 32'h1, d, f);
        checks++;
        if (d !== NOP || f !== 1'b1) begin
            errors++; $display("FAIL reset_misaligned data=%h fault=%b exp %h 1", d, f, NOP);
        end
    endtask

    task automatic test_full_word();
        word d; logic f;
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        pulse_start();
        drive_idle();
        checks++;
        if (loading !== 1'b1 || prog_ready !== 1'b1) begin
            errors++; $display("FAIL start_ctrl loading=%b ready=%b exp 1 1", loading, prog_ready);
        end
        for (int i = 0; i < 8; i++) drive_byte(img[i], i == 7);
        drive_idle();
        checks++;
        if (loading !== 1'b0 || words_loaded !== WL_W'(2)) begin
            errors++; $display("FAIL full_done loading=%b words=%0d exp 0 2", loading, words_loaded);
        end
        model_load(8);
        rd(MEM_READ_EN, 32'h0, d, f);
        checks++;
        if (d !== 32'h0000_0013 || f !== 1'b0) begin
            errors++; $display("FAIL full_rd0 data=%h fault=%b exp 00000013 0", d, f);
        end
        rd(MEM_READ_EN, 32'h4, d, f);
        checks++;
        if (d !== 32'h0010_0093 || f !== 1'b0) begin
            errors++; $display("FAIL full_rd4 data=%h fault=%b exp 00100093 0", d, f);
        end
    endtask

    task automatic test_partial_flush();
        word d; logic f;
        img = '{8'hAA, 8'hBB, 8'hCC};
        pulse_start();
        drive_byte(8'hAA, 1'b0);
        drive_byte(8'hBB, 1'b0);
        drive_byte(8'hCC, 1'b1);
        drive_idle();
        checks++;
        if (loading !== 1'b1 || prog_ready !== 1'b0) begin
            errors++; $display("FAIL flush_state loading=%b ready=%b exp 1 0", loading, prog_ready);
        end
        rd(MEM_READ_EN, 32'h0, d, f);
        checks++;
        if (d !== NOP) begin
            errors++; $display("FAIL flush_rd_busy data=%h exp %h", d, NOP);
        end
        drive_idle();
        checks++;
        if (loading !== 1'b0 || words_loaded !== WL_W'(1)) begin
            errors++; $display("FAIL flush_done loading=%b words=%0d exp 0 1", loading, words_loaded);
        end
        model_load(3);
        rd(MEM_READ_EN, 32'h0, d, f);
        checks++;
        if (d !== 32'h00CC_BBAA) begin
            errors++; $display("FAIL flush_rd0 data=%h exp 00ccbbaa", d);
        end
        rd(MEM_READ_EN, 32'h4, d, f);
        checks++;
        if (d !== 32'h0010_0093) begin
            errors++; $display("FAIL flush_rd4_kept data=%h exp 00100093", d);
        end
    endtask

    task automatic test_invalid_reads();
        word d; logic f; word a; mem_en_t op;
        @(negedge clock);
        rd(MEM_READ_EN, 32'h2, d, f);
        checks++;
        if (d !== NOP || f !== 1'b1) begin
            errors++; $display("FAIL inv_misaligned data=%h fault=%b exp %h 1", d, f, NOP);
        end
        rd(MEM_READ_EN, 4 * DEPTH, d, f);
        checks++;
        if (d !== NOP || f !== 1'b1) begin
            errors++; $display("FAIL inv_range data=%h fault=%b exp %h 1", d, f, NOP);
        end
        rd(MEM_IDLE, 32'h4, d, f);
        checks++;
        if (d !== NOP || f !== 1'b0) begin
            errors++; $display("FAIL inv_op_idle data=%h fault=%b exp %h 0", d, f, NOP);
        end
        rd(MEM_WRITE_EN, 32'h2, d, f);
        checks++;
        if (d !== NOP || f !== 1'b0) begin
            errors++; $display("FAIL inv_op_write data=%h fault=%b exp %h 0", d, f, NOP);
        end
        for (int i = 0; i < 24; i++) begin
            a  = ($urandom_range(0, 7) == 0) ? word'($urandom) : word'($urandom_range(0, 23));
            op = ($urandom_range(0, 3) == 0) ? MEM_IDLE : MEM_READ_EN;
            @(negedge clock);
            rd(op, a, d, f);
            if (op != MEM_READ_EN || exp_fault(a) || model_vld[a[3:2]]) begin
                word  ed = (op == MEM_READ_EN && !exp_fault(a)) ? model_mem[a[3:2]] : NOP;
                logic ef = (op == MEM_READ_EN) && exp_fault(a);
                checks++;
                if (d !== ed || f !== ef) begin
                    errors++; $display("FAIL rand_read a=%h data=%h fault=%b exp %h %b", a, d, f, ed, ef);
                end
            end
        end
    endtask

    task automatic test_overflow();
        word d; logic f;
        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
        pulse_start();
        for (int i = 0; i < 20; i++) drive_byte(img[i], i == 19);
        drive_idle();
        checks++;
        if (words_loaded !== WL_W'(DEPTH) || prog_overflow !== 1'b1 || loading !== 1'b0) begin
            errors++; $display("FAIL ovf_done words=%0d ovf=%b loading=%b exp %0d 1 0",
                               words_loaded, prog_overflow, loading, DEPTH);
        end
        model_load(20);
        for (int w = 0; w < int'(DEPTH); w++) begin
            @(negedge clock);
            rd(MEM_READ_EN, word'(4 * w), d, f);
            checks++;
            if (d !== model_mem[w]) begin
                errors++; $display("FAIL ovf_rd w=%0d data=%h exp %h", w, d, model_mem[w]);
            end
        end
        pulse_start();
        drive_idle();
        checks++;
        if (prog_overflow !== 1'b0 || words_loaded !== '0 || prog_ready !== 1'b1) begin
            errors++; $display("FAIL ovf_clear ovf=%b words=%0d ready=%b exp 0 0 1",
                               prog_overflow, words_loaded, prog_ready);
        end
        img = '{8'h5A};
        drive_byte(8'h5A, 1'b1);
        drive_idle();
        drive_idle();
        model_load(1);
        rd(MEM_READ_EN, 32'h0, d, f);
        checks++;
        if (d !== 32'h0000_005A || words_loaded !== WL_W'(1)) begin
            errors++; $display("FAIL ovf_reload data=%h words=%0d exp 0000005a 1", d, words_loaded);
        end
    endtask

    task automatic test_restart();
        word d; logic f;
        pulse_start();
        drive_byte(8'($urandom), 1'b0);
        drive_byte(8'($urandom), 1'b0);
        // Restart with a byte presented in the same cycle: the byte must be dropped
        @(negedge clock);
        prog_start = 1'b1; prog_valid = 1'b1; prog_byte = 8'hEE; prog_last = 1'b0;
        img.delete();
        for (int i = 0; i < 4; i++) img.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) drive_byte(img[i], i == 3);
        drive_idle();
        model_load(4);
        checks++;
        if (loading !== 1'b0 || words_loaded !== WL_W'(1)) begin
            errors++; $display("FAIL restart_done loading=%b words=%0d exp 0 1", loading, words_loaded);
        end
        rd(MEM_READ_EN, 32'h0, d, f);
        checks++;
        if (d !== model_mem[0]) begin
            errors++; $display("FAIL restart_rd0 data=%h exp %h", d, model_mem[0]);
        end
        rd(MEM_READ_EN, 32'h4, d, f);
        checks++;
        if (d !== model_mem[1]) begin
            errors++; $display("FAIL restart_rd4 data=%h exp %h", d, model_mem[1]);
        end
    endtask

    task automatic test_reset_mid_load();
        word d; logic f;
        img.delete();
        for (int i = 0; i < 5; i++) img.push_back(8'($urandom));
        pulse_start();
        for (int i = 0; i < 5; i++) drive_byte(img[i], 1'b0);
        drive_idle();
        #1 reset = 1'b1;
        #1;
        checks++;
        if (loading !== 1'b0 || prog_ready !== 1'b0 || words_loaded !== '0) begin
            errors++; $display("FAIL midreset loading=%b ready=%b words=%0d exp 0 0 0",
                               loading, prog_ready, words_loaded);
        end
        @(negedge clock);
        reset = 1'b0;
        model_load(4);
        @(negedge clock);
        rd(MEM_READ_EN, 32'h0, d, f);
        checks++;
        if (d !== model_mem[0]) begin
            errors++; $display("FAIL midreset_rd0 data=%h exp %h", d, model_mem[0]);
        end
        rd(MEM_READ_EN, 32'h4, d, f);
        checks++;
        if (d !== model_mem[1]) begin
            errors++; $display("FAIL midreset_rd4 data=%h exp %h", d, model_mem[1]);
        end
    endtask

    task automatic test_random_loads();
        word d; logic f; word a;
        for (int it = 0; it < 8; it++) begin
            int n = $urandom_range(1, 20);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            pulse_start();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) drive_idle();
                drive_byte(img[i], i == n - 1);
                a = word'($urandom_range(0, 23));
                rd(MEM_READ_EN, a, d, f);
                checks++;
                if (d !== NOP || f !== exp_fault(a)) begin
                    errors++; $display("FAIL busy_read a=%h data=%h fault=%b exp %h %b",
                                       a, d, f, NOP, exp_fault(a));
                end
            end
            drive_idle();
            if (n % 4 != 0) begin
                checks++;
                if (loading !== 1'b1 || prog_ready !== 1'b0) begin
                    errors++; $display("FAIL rand_flush n=%0d loading=%b ready=%b exp 1 0",
                                       n, loading, prog_ready);
                end
                drive_idle();
            end
            model_load(n);
            checks++;
            if (loading !== 1'b0 || words_loaded !== WL_W'(exp_words(n))
                || prog_overflow !== (n > 4 * int'(DEPTH))) begin
                errors++; $display("FAIL rand_done n=%0d loading=%b words=%0d ovf=%b exp 0 %0d %b",
                                   n, loading, words_loaded, prog_overflow, exp_words(n),
                                   n > 4 * int'(DEPTH));
            end
            for (int w = 0; w < int'(DEPTH); w++) begin
                @(negedge clock);
                rd(MEM_READ_EN, word'(4 * w), d, f);
                checks++;
                if (d !== model_mem[w] || f !== 1'b0) begin
                    errors++; $display("FAIL rand_rd n=%0d w=%0d data=%h fault=%b exp %h 0",
                                       n, w, d, f, model_mem[w]);
                end
            end
        end
    endtask

    initial begin
        for (int w = 0; w < int'(DEPTH); w++) begin
            model_mem[w] = '0;
            model_vld[w] = 1'b0;
        end
        test_reset();
        test_full_word();
        test_partial_flush();
        test_invalid_reads();
        test_overflow();
        test_restart();
        test_reset_mid_load();
        test_random_loads();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder that serves the fetch stage's read requests. It returns a 32-bit instruction word, combinationally, in the same cycle as the requested address. It also contains a byte-serial programming port with a load state machine that assembles bytes into little-endian words and writes them sequentially from address 0. It sits between the fetch stage's memory interface and the board-level program loader; `loading` is wired into the core's reset so the core is held while a program is written.

## Interface

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
- NOP_WORD, 32'h0000_0013, word returned for any non-servable read

Ports:
- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high
- mem_op  in  mem_en_t  read request; only MEM_READ_EN is serviced
- memory_inst_address  in  word  byte address from fetch
- memory_inst_data  out  word  instruction returned to fetch
- inst_fault  out  1  read was misaligned or out of range (combinational)
- prog_start  in  1  single-cycle pulse that starts or restarts a load
- prog_valid  in  1  prog_byte is valid
- prog_byte  in  8  program byte, in little-endian order
- prog_last  in  1  qualifies the final byte of the image
- prog_ready  out  1  byte accepted when prog_valid && prog_ready
- loading  out  1  high whenever state != IDLE
- words_loaded  out  $clog2(DEPTH_WORDS)+1  words written since last prog_start
- prog_overflow  out  1  sticky: a byte arrived after the array was full

## Operation

- States: IDLE, LOAD, FLUSH.
- IDLE:
  - prog_start → LOAD.
  - Clears write pointer, byte_cnt (2-bit), words_loaded and prog_overflow.
- LOAD:
  - prog_ready = 1.
  - On each accepted byte:
    - shift into lane byte_cnt of the assembly register;
    - increment byte_cnt (wraps 3→0).
  - Accepting lane 3 writes {lane3..lane0} to mem[ptr] and increments ptr and words_loaded.
  - prog_last on an accepted byte with byte_cnt==3: write the word, → IDLE.
  - prog_last with byte_cnt<3: → FLUSH.
  - prog_start in LOAD restarts the load: ptr, byte_cnt and words_loaded are cleared, and the partial word is discarded. The restart takes priority over a simultaneous byte.
- FLUSH:
  - prog_ready = 0.
  - Writes the partial word with its unfilled upper lanes zero, increments ptr and words_loaded, → IDLE. Takes one cycle.
- Full array (ptr == DEPTH_WORDS):
  - Bytes are still accepted so the loader never deadlocks.
  - No write occurs and ptr/words_loaded saturate.
  - prog_overflow is set and stays set until the next prog_start.
  - prog_last still returns the FSM to IDLE (FLUSH does not write).
- Read path, combinational:
  - memory_inst_data = mem[memory_inst_address[$clog2(DEPTH_WORDS)+1:2]] only when all of:
    - mem_op == MEM_READ_EN,
    - address[1:0] == 0,
    - address < 4*DEPTH_WORDS,
    - state == IDLE.
  - Otherwise memory_inst_data = NOP_WORD.
- inst_fault = (mem_op == MEM_READ_EN) && (misaligned || out of range). It is independent of state.

## Timing

- Read latency: zero cycles, because the fetch stage samples data in the same cycle it drives the address.
- Writes occur on the rising edge at which the completing byte is accepted (LOAD) or on the FLUSH edge. They are visible to reads in the following cycle.
- prog_start → loading = 1 and prog_ready = 1 from the next cycle.
- After the final write, loading falls on the same edge that enters IDLE.
- Values after reset:
  - state = IDLE, loading = 0, prog_ready = 0;
  - ptr, byte_cnt, words_loaded = 0;
  - prog_overflow = 0.
  - The memory array is not cleared; contents are retained across reset.
- Reset mid-load: the FSM returns to IDLE immediately (asynchronously). Words already written stay in memory and the partial word is lost.
- prog_valid without prog_ready (in IDLE or FLUSH): the byte is ignored. The loader must hold it until prog_ready.

## Test plan

- **Full-word load then fetch:**
  - Stimulus: prog_start, then bytes 13,00,00,00,93,00,10,00 with prog_last on the 8th byte.
  - Required: words_loaded=2 and loading=0 one cycle after the last byte; read of 0x0 → 0x00000013; read of 0x4 → 0x00100093.
- **Partial-word flush:**
  - Stimulus: bytes AA,BB,CC with prog_last on CC.
  - Required: FLUSH for one cycle with prog_ready=0; read of 0x0 → 0x00CCBBAA; words_loaded=1.
- **Invalid reads:**
  - Read of 0x2 → NOP_WORD with inst_fault=1.
  - Read of 4*DEPTH_WORDS → NOP_WORD with inst_fault=1.
  - mem_op ≠ MEM_READ_EN → NOP_WORD with inst_fault=0.
  - Any read while loading=1 → NOP_WORD.
- **Overflow:**
  - Stimulus (DEPTH_WORDS=4): load 20 bytes.
  - Required: words_loaded saturates at 4 and prog_overflow=1; mem[0..3] hold bytes 0–15; prog_overflow clears on the next prog_start.
- **Restart and reset mid-load:**
  - Stimulus: 2 bytes, then prog_start.
  - Required: the partial word is discarded and the next 4 bytes land at 0x0.
  - Stimulus: assert reset after 5 bytes.
  - Required: loading=0 immediately; word 0 is retained; words_loaded=0.
